// File: rtl/alu_exec_ctrl.sv
// Purpose : sequencing stage around a combinational ALU; reads operands from an
//           internal register file, feeds the ALU from registers, writes back the result.
// Latency : accept edge to done-high is 2 cycles; throughput one instruction per 2 cycles.
// Backpr. : ins_ready is low while an instruction is in EXEC; ins_valid is ignored there.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   ins_valid/ins_ready      - instruction handshake (ins_op, ins_rd, ins_rs1, ins_rs2)
//   ld_en/ld_addr/ld_data    - side-port register-file write, accepted in any state
//   rd_addr/rd_data          - combinational observation read (register 0 reads 0)
//   alu_enable/alu_op/src1/src2, alu_out/alu_overflow - ALU interface
//   done/result              - writeback pulse and last written-back value
//   ovf_flag/ovf_clr/ovf_count - sticky overflow flag, its clear, saturating event count
module alu_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [OP_W-1:0]   ins_op,
  input  logic [RA_W-1:0]   ins_rd,
  input  logic [RA_W-1:0]   ins_rs1,
  input  logic [RA_W-1:0]   ins_rs2,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf_flag,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int DEPTH = 1 << RA_W;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] rf [DEPTH];

  assign ins_ready = (state == IDLE) & ~rst;

  // Entry 0 is never written, but the read is gated anyway so it is
  // zero by construction rather than by history.
  assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_q       <= '0;
      alu_enable <= 1'b0;
      alu_op     <= '0;
      src1       <= '0;
      src2       <= '0;
      done       <= 1'b0;
      result     <= '0;
      ovf_flag   <= 1'b0;
      ovf_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      // Side-port load first: a writeback to the same address later in this
      // block overrides it.
      if (ld_en && (ld_addr != '0)) begin
        rf[ld_addr] <= ld_data;
      end

      // Clear first so that an overflow on the same edge re-sets the flag.
      if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ins_valid) begin
            // Non-blocking reads see the pre-edge register file, so a
            // simultaneous ld to a source does not leak into the operand.
            src1       <= (ins_rs1 == '0) ? '0 : rf[ins_rs1];
            src2       <= (ins_rs2 == '0) ? '0 : rf[ins_rs2];
            alu_op     <= ins_op;
            rd_q       <= ins_rd;
            alu_enable <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (rd_q != '0) begin
            rf[rd_q] <= alu_out;
          end
          result     <= alu_out;
          done       <= 1'b1;
          alu_enable <= 1'b0;
          if (alu_overflow) begin
            ovf_flag <= 1'b1;
            if (ovf_count != '1) begin
              ovf_count <= ovf_count + 1'b1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic        ins_ready;
  logic [3:0]  ins_op;
  logic [4:0]  ins_rd, ins_rs1, ins_rs2;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        alu_enable;
  logic [3:0]  alu_op;
  logic [31:0] src1, src2;
  logic [31:0] alu_out;
  logic        alu_overflow;
  logic        done;
  logic [31:0] result;
  logic        ovf_flag;
  logic        ovf_clr;
  logic [7:0]  ovf_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(32), .OP_W(4), .RA_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_op(ins_op), .ins_rd(ins_rd), .ins_rs1(ins_rs1), .ins_rs2(ins_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_enable(alu_enable), .alu_op(alu_op), .src1(src1), .src2(src2),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .done(done), .result(result),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  // Stand-in combinational ALU: ADD=0, SUB=1, ROTR=7, anything else XOR.
  logic [63:0] rot_w;
  always_comb begin
    alu_out      = src1 ^ src2;
    alu_overflow = 1'b0;
    rot_w        = {src1, src1} >> src2[4:0];
    case (alu_op)
      4'h0: begin
        alu_out      = src1 + src2;
        alu_overflow = (src1[31] == src2[31]) && (alu_out[31] != src1[31]);
      end
      4'h1: begin
        alu_out      = src1 - src2;
        alu_overflow = (src1[31] != src2[31]) && (alu_out[31] != src1[31]);
      end
      4'h7: alu_out = rot_w[31:0];
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic setup_ins(input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    ins_op = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2; ins_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (ins_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst got %b want 0", ins_ready); end
    rst = 1'b0;
    rd_addr = 5'd5; #1;
    vectors++;
    if ({alu_enable, alu_op, src1, src2, done, result, ovf_flag, ovf_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs en=%b op=%h s1=%h s2=%h done=%b res=%h flag=%b cnt=%0d want all 0",
               alu_enable, alu_op, src1, src2, done, result, ovf_flag, ovf_count);
    end
    vectors++;
    if (ins_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got %b want 1", ins_ready); end
    vectors++;
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rf got %h want 0", rd_data); end
  endtask

  task automatic test_ovf_add();
    load(5'd1, 32'h7FFF_FFFF);
    load(5'd2, 32'h0000_0001);
    setup_ins(4'h0, 5'd3, 5'd1, 5'd2);
    vectors++;
    if (ins_ready !== 1'b1) begin miscompares++; $display("FAIL add_ready got %b want 1", ins_ready); end
    tick();
    ins_valid = 1'b0;
    vectors++;
    if ({ins_ready, alu_enable, done, alu_op, src1, src2} !== {1'b0, 1'b1, 1'b0, 4'h0, 32'h7FFF_FFFF, 32'h1}) begin
      miscompares++;
      $display("FAIL add_exec rdy=%b en=%b done=%b op=%h s1=%h s2=%h want 0 1 0 0 7fffffff 1",
               ins_ready, alu_enable, done, alu_op, src1, src2);
    end
    tick();
    rd_addr = 5'd3; #1;
    vectors++;
    if ({done, ins_ready, alu_enable, result, rd_data} !== {1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL add_done done=%b rdy=%b en=%b res=%h rf3=%h want 1 1 0 80000000 80000000",
               done, ins_ready, alu_enable, result, rd_data);
    end
    vectors++;
    if ({ovf_flag, ovf_count} !== {1'b1, 8'd1}) begin
      miscompares++; $display("FAIL add_ovf flag=%b cnt=%0d want 1 1", ovf_flag, ovf_count);
    end
    tick();
    vectors++;
    if ({done, result, alu_op, src1} !== {1'b0, 32'h8000_0000, 4'h0, 32'h7FFF_FFFF}) begin
      miscompares++;
      $display("FAIL add_hold done=%b res=%h op=%h s1=%h want 0 80000000 0 7fffffff", done, result, alu_op, src1);
    end
  endtask

  task automatic test_rotr();
    load(5'd1, 32'h8000_0001);
    load(5'd2, 32'h0000_0004);
    setup_ins(4'h7, 5'd5, 5'd1, 5'd2);
    tick();
    ins_valid = 1'b0;
    tick();
    rd_addr = 5'd5; #1;
    vectors++;
    if ({done, result, rd_data} !== {1'b1, 32'h1800_0000, 32'h1800_0000}) begin
      miscompares++; $display("FAIL rotr done=%b res=%h rf5=%h want 1 18000000 18000000", done, result, rd_data);
    end
    vectors++;
    if ({ovf_flag, ovf_count} !== {1'b1, 8'd1}) begin
      miscompares++; $display("FAIL rotr_ovf flag=%b cnt=%0d want 1 1", ovf_flag, ovf_count);
    end
  endtask

  task automatic test_reg0();
    load(5'd1, 32'd10);
    load(5'd2, 32'd3);
    setup_ins(4'h1, 5'd0, 5'd1, 5'd2);
    tick();
    ins_valid = 1'b0;
    tick();
    rd_addr = 5'd0; #1;
    vectors++;
    if ({done, result, rd_data, ovf_count} !== {1'b1, 32'd7, 32'd0, 8'd1}) begin
      miscompares++;
      $display("FAIL reg0_wb done=%b res=%h rf0=%h cnt=%0d want 1 7 0 1", done, result, rd_data, ovf_count);
    end
    load(5'd0, 32'h0000_1234);
    vectors++;
    if (rd_data !== 32'd0) begin miscompares++; $display("FAIL reg0_ld got %h want 0", rd_data); end
  endtask

  task automatic test_back_to_back();
    // R1=10, R2=3 -> XOR (op 2) = 9, written to R8, R9, R10.
    for (int c = 0; c <= 6; c++) begin
      if (c % 2 == 0 && c <= 4) setup_ins(4'h2, 5'(8 + c / 2), 5'd1, 5'd2);
      if (c == 6) ins_valid = 1'b0;
      #1;
      vectors++;
      if (ins_ready !== (c % 2 == 0)) begin
        miscompares++; $display("FAIL b2b_ready cycle %0d got %b want %b", c, ins_ready, (c % 2 == 0));
      end
      vectors++;
      if (done !== (c >= 2 && c % 2 == 0)) begin
        miscompares++; $display("FAIL b2b_done cycle %0d got %b want %b", c, done, (c >= 2 && c % 2 == 0));
      end
      tick();
    end
    for (int r = 8; r <= 10; r++) begin
      rd_addr = 5'(r); #1;
      vectors++;
      if (rd_data !== 32'd9) begin miscompares++; $display("FAIL b2b_rf R%0d got %h want 9", r, rd_data); end
    end
  endtask

  task automatic test_collision();
    // ld to R1 on the accept edge: operand must see the old value 10.
    setup_ins(4'h0, 5'd7, 5'd1, 5'd2);
    ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'h55;
    tick();
    ins_valid = 1'b0;
    ld_addr = 5'd7; ld_data = 32'hDEAD_BEEF;
    vectors++;
    if (src1 !== 32'd10) begin miscompares++; $display("FAIL coll_src1 got %h want a", src1); end
    tick();
    ld_en = 1'b0;
    rd_addr = 5'd7; #1;
    vectors++;
    if (rd_data !== 32'd13) begin miscompares++; $display("FAIL coll_rf7 got %h want d", rd_data); end
    rd_addr = 5'd1; #1;
    vectors++;
    if (rd_data !== 32'h55) begin miscompares++; $display("FAIL coll_rf1 got %h want 55", rd_data); end

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++;
    if ({ovf_flag, ovf_count} !== {1'b0, 8'd1}) begin
      miscompares++; $display("FAIL ovf_clr flag=%b cnt=%0d want 0 1", ovf_flag, ovf_count);
    end
    load(5'd1, 32'h7FFF_FFFF);
    load(5'd2, 32'h1);
    setup_ins(4'h0, 5'd0, 5'd1, 5'd2);
    tick();
    ins_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++;
    if ({ovf_flag, ovf_count} !== {1'b1, 8'd2}) begin
      miscompares++; $display("FAIL ovf_set_wins flag=%b cnt=%0d want 1 2", ovf_flag, ovf_count);
    end
  endtask

  task automatic test_mid_reset();
    load(5'd11, 32'h0000_00AA);
    setup_ins(4'h0, 5'd11, 5'd1, 5'd2);
    tick();
    ins_valid = 1'b0;
    rst = 1'b1;
    tick();
    rd_addr = 5'd11; #1;
    vectors++;
    if ({done, alu_enable, alu_op, src1, src2, result, ovf_flag, ovf_count, rd_data} !== '0) begin
      miscompares++;
      $display("FAIL midrst_state done=%b en=%b s1=%h res=%h flag=%b cnt=%0d rf11=%h want all 0",
               done, alu_enable, src1, result, ovf_flag, ovf_count, rd_data);
    end
    vectors++;
    if (ins_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready_in_rst got %b want 0", ins_ready); end
    rst = 1'b0; #1;
    vectors++;
    if (ins_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", ins_ready); end
    tick();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b want 0", done); end
  endtask

  task automatic test_ovf_saturate();
    load(5'd1, 32'h7FFF_FFFF);
    load(5'd2, 32'h1);
    for (int n = 1; n <= 256; n++) begin
      setup_ins(4'h0, 5'd0, 5'd1, 5'd2);
      tick();
      ins_valid = 1'b0;
      tick();
      if (n == 1 || n == 255 || n == 256) begin
        vectors++;
        if (ovf_count !== ((n == 256) ? 8'd255 : 8'(n))) begin
          miscompares++; $display("FAIL sat_count after %0d got %0d want %0d", n, ovf_count, (n == 256) ? 255 : n);
        end
      end
    end
    vectors++;
    if (ovf_flag !== 1'b1) begin miscompares++; $display("FAIL sat_flag got %b want 1", ovf_flag); end
  endtask

  initial begin
    rst = 1'b1; ins_valid = 1'b0; ins_op = '0; ins_rd = '0; ins_rs1 = '0; ins_rs2 = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0; ovf_clr = 1'b0;
    test_reset();
    test_ovf_add();
    test_rotr();
    test_reg0();
    test_back_to_back();
    test_collision();
    test_mid_reset();
    test_ovf_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Sequencing stage that wraps the combinational ALU. It is the ALU's upstream feeder and its downstream consumer.
- Accepts one decoded instruction per handshake.
- Reads both operands from an internal register file and drives the ALU inputs from registers.
- Writes the ALU result back to the register file and tracks overflow events.
- Register file is loaded and observed through side ports by the testbench or the surrounding core.

Parameters:
DATA_W, 32, datapath width; must match the ALU data width.
OP_W, 4, ALU opcode width; must match the ALU opcode width.
RA_W, 5, register address width; register file holds 2**RA_W entries.
CNT_W, 8, width of the overflow event counter.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
ins_valid  in  1  instruction offered.
ins_ready  out  1  block can accept an instruction.
ins_op  in  OP_W  ALU opcode.
ins_rd  in  RA_W  destination register.
ins_rs1  in  RA_W  source 1 register (drives ALU src1).
ins_rs2  in  RA_W  source 2 register (drives ALU src2).
ld_en  in  1  external register-file write strobe.
ld_addr  in  RA_W  external write address.
ld_data  in  DATA_W  external write data.
rd_addr  in  RA_W  observation read address.
rd_data  out  DATA_W  combinational read of the register file; reg 0 reads 0.
alu_enable  out  1  to ALU.
alu_op  out  OP_W  to ALU.
src1  out  DATA_W  to ALU.
src2  out  DATA_W  to ALU.
alu_out  in  DATA_W  from ALU.
alu_overflow  in  1  from ALU.
done  out  1  one-cycle pulse: writeback completed.
result  out  DATA_W  last written-back value; held until the next done.
ovf_flag  out  1  sticky overflow flag.
ovf_clr  in  1  clears ovf_flag.
ovf_count  out  CNT_W  saturating count of overflowing instructions.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; alu_enable, alu_op, src1, src2, done, result, ovf_flag, ovf_count all 0; every register-file entry 0.
- FSM has two states, IDLE and EXEC.
- ins_ready = (state==IDLE) & ~rst.
- IDLE:
  - If ins_valid is high, accept the instruction.
  - Registered on that edge: src1<=RF[rs1], src2<=RF[rs2] (pre-edge values), alu_op<=ins_op, rd latched, alu_enable<=1; go to EXEC.
- EXEC (exactly one cycle):
  - ALU output is sampled at the end of the cycle.
  - On that edge: RF[rd]<=alu_out (skipped if rd==0), result<=alu_out, done<=1, alu_enable<=0; go to IDLE.
- Latency: accept edge to done-high is 2 cycles. Maximum throughput is one instruction per 2 cycles.
- done and a new ins_ready are high in the same cycle.
- alu_op, src1 and src2 hold their last values while idle; only alu_enable drops.
- Register 0: reads always return 0; writes from both writeback and ld are discarded.
- Overflow, evaluated on the EXEC edge:
  - If alu_overflow is 1: ovf_flag<=1 and ovf_count increments, saturating at 2**CNT_W-1.
  - The writeback happens regardless of overflow.
  - ovf_clr clears ovf_flag only, never ovf_count.
  - ovf_clr and a new overflow in the same cycle: the set wins.
- ld port:
  - Accepted in any state.
  - ld and writeback to the same address on the same edge: writeback wins.
  - ld on the accept edge to a source register: the operand gets the pre-edge value.
- Reset asserted during EXEC: no writeback, no done, everything returns to reset values on that edge.
- ins_valid is ignored while in EXEC.
- The ALU operates on whatever opcode is given (all 16 opcodes are legal); the block never decodes ins_op.

Test Plan:
- Overflowing ADD: ld R1=0x7FFFFFFF, R2=0x00000001; issue ADD (0000), rd=3 -> done 2 cycles after accept; result=RF[3]=0x80000000; ovf_flag=1; ovf_count=1.
- ROTR: R1=0x80000001, R2=4; issue ROTR (0111), rd=5 -> RF[5]=0x18000000; ovf_flag unchanged.
- Register 0 protection: issue SUB, rd=0 -> done pulses, result updates, rd_data(0)=0. Also ld_en to addr 0 -> still reads 0.
- Back-to-back: ins_valid held high for 3 instructions -> accepts at cycles 0, 2, 4; done at cycles 2, 4, 6; ins_ready low on cycles 1, 3, 5.
- Collision: in the EXEC cycle writing R7, ld_en R7=0xDEADBEEF -> RF[7] = ALU result. Separately, ovf_clr in the same cycle as a new overflow -> ovf_flag stays 1.
- Mid-op reset: rst high during EXEC -> RF[rd] unchanged (0 after reset), done never pulses, all outputs 0 next cycle, ins_ready=1 once rst drops. Also 256 overflows -> ovf_count=255.
